pc_gen: RTL and testbench
=========================

# pc_gen

Program-counter generator feeding the fetch-stage pipeline register. Each cycle it produces the 8-bit fetch address that the fetch register latches, and it handles sequential increment, stalls, branch/jump redirection, downstream squash signalling and halt/resume. It is the producer side of the fetch register's `pc` input. A redirect asserts a squash window for wrong-path instructions already in flight.

## Interface
- `PC_WIDTH`, 8, width of the program counter.
- `RESET_VECTOR`, 8'h00, first fetch address after reset.
- `FLUSH_CYCLES`, 2, length of the squash window after a redirect (1..7).
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `stall`  in  1  hold the current pc (hazard unit).
- `branch_taken`  in  1  branch resolved taken this cycle.
- `branch_target`  in  PC_WIDTH  branch destination.
- `jump`  in  1  unconditional jump this cycle.
- `jump_target`  in  PC_WIDTH  jump destination.
- `halt_req`  in  1  request to stop fetching.
- `resume`  in  1  leave HALT.
- `pc`  out  PC_WIDTH  registered fetch address, driven to the fetch register.
- `pc_valid`  out  1  `pc` is a real fetch this cycle.
- `pc_plus1`  out  PC_WIDTH  combinational `pc + 1`, modulo 2^PC_WIDTH.
- `squash`  out  1  downstream stages must kill their in-flight instructions.
- `halted`  out  1  block is in HALT.
- `wrap`  out  1  one-cycle pulse when a sequential increment wraps from all-ones to 0.

## Operation
- **FSM states:** BOOT, RUN, FLUSH, HALT. Registered state, pc, squash counter and wrap flag.
- **BOOT:** entered on reset.
  - `pc=RESET_VECTOR`, `pc_valid=0`; no inputs are sampled.
  - Goes to RUN on the next edge, with pc unchanged.
- **RUN/FLUSH priority**, evaluated each cycle: jump > branch_taken > halt_req > stall > increment.
  - Jump: `pc<=jump_target`, state FLUSH, counter loaded with FLUSH_CYCLES.
  - Branch: same as jump, using `branch_target`.
  - Redirects override `stall`.
  - halt_req: state HALT, pc held.
  - stall: pc held.
  - Otherwise: `pc<=pc+1`. If pc was all-ones, pc becomes 0 and `wrap` pulses the next cycle.
- **FLUSH:**
  - `squash=1`.
  - Counter decrements each cycle; at 1 the state returns to RUN.
  - A new redirect in FLUSH reloads the counter and retargets pc.
  - `stall` does not freeze the counter.
  - halt_req in FLUSH takes effect only after the counter expires.
- **HALT:**
  - `pc_valid=0`, `halted=1`, pc held.
  - branch_taken, jump and stall are ignored.
  - `resume` moves to RUN; fetch continues from the held pc.
  - If resume and halt_req are both high, HALT is kept.
- **pc_valid:**
  - 1 in RUN and FLUSH when stall is low.
  - 0 in BOOT, in HALT, and when stall is high without a redirect.

## Timing
- **Reset values:** `pc=RESET_VECTOR`, `pc_valid=0`, `squash=0`, `halted=0`, `wrap=0`, state BOOT.
- **Reset precedence:** `reset` low at an edge overrides every other input, in any state, including mid-FLUSH.
- **Redirect latency:** redirect sampled at edge N gives `pc=target` and `squash=1` from N+1 through N+FLUSH_CYCLES. `squash=0` at N+FLUSH_CYCLES+1.
- **Increment latency:** one cycle. `pc_plus1` follows `pc` combinationally with zero latency.
- **halt_req latency:** sampled at N gives `halted=1` from N+1.
- **resume latency:** sampled at N gives `pc_valid=1` at N+1 with the held pc.
- **Simultaneous jump and branch_taken:** jump wins; branch_target is discarded.

## Structure
- Shared package (`pc_gen_pkg`) holds:
  - the state enum {BOOT, RUN, FLUSH, HALT};
  - the default widths;
  - `FLUSH_CNT_W = 3`.
- Single module, no sub-modules. The next-pc mux and the FSM live in one always-block pair: a registered block plus a combinational next-state block.

## Test plan
- **Reset and boot:** hold reset low 3 cycles, then release.
  - `pc=0x00`, `pc_valid=0` for 1 cycle.
  - Then pc=0x00, 0x01, 0x02 with `pc_valid=1`.
- **Stall:** assert stall for 2 cycles at pc=0x05.
  - pc stays 0x05 and `pc_valid=0` for 2 cycles.
  - pc=0x06 on the cycle after stall drops.
- **Jump vs branch:** jump to 0x40 with branch_taken to 0x80 in the same cycle.
  - Next pc=0x40.
  - `squash` high for exactly 2 cycles, with pc 0x40 then 0x41.
- **Wrap:** run from pc=0xFE.
  - pc goes 0xFF then 0x00.
  - `wrap` is high for one cycle, coincident with pc=0x00.
- **Halt/resume:** halt_req at pc=0x10, then resume 3 cycles later.
  - `halted=1` and `pc_valid=0` for 3 cycles; a branch_taken during HALT is ignored.
  - After resume, pc=0x10 with `pc_valid=1`.
- **Reset mid-FLUSH:** branch to 0x20, then reset low on the next cycle.
  - `squash=0` and `pc=0x00` immediately after that edge; state BOOT.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// Shared types and default sizes for the program-counter generator.
package pc_gen_pkg;

   typedef enum logic [1:0] {
      StBoot,
      StRun,
      StFlush,
      StHalt
   } pc_state_e;

   localparam int unsigned DefPcWidth     = 8;
   localparam int unsigned DefFlushCycles = 2;
   localparam int unsigned FLUSH_CNT_W    = 3;

endpackage

// File: rtl/pc_gen.sv
// Fetch-address generator: sequential increment, stall, redirect with squash window,
// and halt/resume.
module pc_gen
   import pc_gen_pkg::*;
#(
   parameter int unsigned          PC_WIDTH     = DefPcWidth,
   parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = '0,
   parameter int unsigned          FLUSH_CYCLES = DefFlushCycles
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                stall,
   input  logic                branch_taken,
   input  logic [PC_WIDTH-1:0] branch_target,
   input  logic                jump,
   input  logic [PC_WIDTH-1:0] jump_target,
   input  logic                halt_req,
   input  logic                resume,
   output logic [PC_WIDTH-1:0] pc,
   output logic                pc_valid,
   output logic [PC_WIDTH-1:0] pc_plus1,
   output logic                squash,
   output logic                halted,
   output logic                wrap
);

   localparam logic [FLUSH_CNT_W-1:0] FlushLoad = FLUSH_CNT_W'(FLUSH_CYCLES);
   localparam logic [FLUSH_CNT_W-1:0] CntOne    = FLUSH_CNT_W'(1);

   pc_state_e                state_q, state_d;
   logic [PC_WIDTH-1:0]      pc_q, pc_d;
   logic [FLUSH_CNT_W-1:0]   cnt_q, cnt_d;
   logic                     wrap_q, wrap_d;
   logic                     redirect;
   logic [PC_WIDTH-1:0]      target;
   logic                     window_done;

   assign redirect = jump | branch_taken;
   assign target   = jump ? jump_target : branch_target;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      cnt_d       = cnt_q;
      wrap_d      = 1'b0;
      window_done = 1'b0;
      unique case (state_q)
         StBoot: state_d = StRun;
         StRun, StFlush: begin
            if (redirect) begin
               pc_d    = target;
               state_d = StFlush;
               cnt_d   = FlushLoad;
            end else begin
               // A halt request waits until the squash window has fully drained.
               window_done = (state_q == StRun) || (cnt_q == CntOne);
               if (state_q == StFlush) begin
                  cnt_d = cnt_q - CntOne;
                  if (cnt_q == CntOne) state_d = StRun;
               end
               if (halt_req && window_done) begin
                  state_d = StHalt;
               end else if (!stall) begin
                  pc_d   = pc_q + PC_WIDTH'(1);
                  wrap_d = &pc_q;
               end
            end
         end
         StHalt: begin
            if (resume && !halt_req) state_d = StRun;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= StBoot;
         pc_q    <= RESET_VECTOR;
         cnt_q   <= '0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
         wrap_q  <= wrap_d;
      end
   end

   assign pc       = pc_q;
   assign pc_plus1 = pc_q + PC_WIDTH'(1);
   assign squash   = (state_q == StFlush);
   assign halted   = (state_q == StHalt);
   assign wrap     = wrap_q;
   assign pc_valid = ((state_q == StRun) || (state_q == StFlush)) && (!stall || redirect);

endmodule

// File: tb/tb_pc_gen.sv
// Directed plus randomized checks of pc_gen against a cycle-level behavioural model.
module tb_pc_gen;

   localparam int FC = 2;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       stall = 1'b0, branch_taken = 1'b0, jump = 1'b0;
   logic       halt_req = 1'b0, resume = 1'b0;
   logic [7:0] branch_target = '0, jump_target = '0;
   logic [7:0] pc, pc_plus1;
   logic       pc_valid, squash, halted, wrap;

   int n_cmp = 0;
   int n_err = 0;

   // Behavioural model: current fetch address, remaining squash cycles, mode flags.
   bit m_known = 0;
   int m_pc    = 0;
   int m_sq    = 0;
   bit m_boot  = 0;
   bit m_halt  = 0;
   bit m_wrap  = 0;

   always #5 clock = ~clock;

   pc_gen #(
      .PC_WIDTH     (8),
      .RESET_VECTOR (8'h00),
      .FLUSH_CYCLES (FC)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jump          (jump),
      .jump_target   (jump_target),
      .halt_req      (halt_req),
      .resume        (resume),
      .pc            (pc),
      .pc_valid      (pc_valid),
      .pc_plus1      (pc_plus1),
      .squash        (squash),
      .halted        (halted),
      .wrap          (wrap)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_step(input bit rst_n, input bit st, input bit br, input int bt,
                             input bit jp, input int jt, input bit hr, input bit rs);
      int left;
      if (!rst_n) begin
         m_known = 1; m_pc = 0; m_sq = 0; m_boot = 1; m_halt = 0; m_wrap = 0;
      end else if (m_boot) begin
         m_boot = 0; m_wrap = 0;
      end else if (m_halt) begin
         m_wrap = 0;
         if (rs && !hr) m_halt = 0;
      end else begin
         m_wrap = 0;
         if (jp) begin
            m_pc = jt; m_sq = FC;
         end else if (br) begin
            m_pc = bt; m_sq = FC;
         end else begin
            left = m_sq;
            if (m_sq > 0) m_sq--;
            if (hr && left <= 1) begin
               m_halt = 1;
            end else if (!st) begin
               m_wrap = (m_pc == 255);
               m_pc   = (m_pc + 1) % 256;
            end
         end
      end
   endtask

   task automatic cycle(input bit rst_n, input bit st, input bit br, input logic [7:0] bt,
                        input bit jp, input logic [7:0] jt, input bit hr, input bit rs);
      @(negedge clock);
      reset = rst_n; stall = st; branch_taken = br; branch_target = bt;
      jump = jp; jump_target = jt; halt_req = hr; resume = rs;
      #1;
      if (m_known) begin
         check_eq("pc", pc, m_pc);
         check_eq("pc_plus1", pc_plus1, (m_pc + 1) % 256);
         check_eq("pc_valid", pc_valid, !m_boot && !m_halt && (!st || jp || br));
         check_eq("squash", squash, m_sq > 0);
         check_eq("halted", halted, m_halt);
         check_eq("wrap", wrap, m_wrap);
      end
      @(posedge clock);
      model_step(rst_n, st, br, int'(bt), jp, int'(jt), hr, rs);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1, 0, 0, 8'h00, 0, 8'h00, 0, 0);
   endtask

   initial begin
      // Reset and boot
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, 8'h00, 0, 8'h00, 0, 0);
      idle(1);
      #1 check_eq("boot_exit_pc", pc, 8'h00);
      idle(5);
      #1 check_eq("seq_pc5", pc, 8'h05);

      // Stall at 0x05
      cycle(1, 1, 0, 8'h00, 0, 8'h00, 0, 0);
      cycle(1, 1, 0, 8'h00, 0, 8'h00, 0, 0);
      #1 check_eq("stall_hold", pc, 8'h05);
      idle(1);
      #1 check_eq("stall_release", pc, 8'h06);

      // Jump beats branch
      cycle(1, 0, 1, 8'h80, 1, 8'h40, 0, 0);
      #1 check_eq("jump_pc", pc, 8'h40);
      check_eq("jump_squash", squash, 1'b1);
      idle(1);
      #1 check_eq("flush_pc2", pc, 8'h41);
      check_eq("flush_squash2", squash, 1'b1);
      idle(1);
      #1 check_eq("flush_end", squash, 1'b0);

      // Wrap
      cycle(1, 0, 0, 8'h00, 1, 8'hFE, 0, 0);
      idle(1);
      #1 check_eq("wrap_ff", pc, 8'hFF);
      idle(1);
      #1 check_eq("wrap_pc0", pc, 8'h00);
      check_eq("wrap_pulse", wrap, 1'b1);
      idle(1);
      #1 check_eq("wrap_clear", wrap, 1'b0);

      // Halt at 0x10, branch ignored, resume
      cycle(1, 0, 0, 8'h00, 1, 8'h0E, 0, 0);
      idle(2);
      #1 check_eq("pre_halt_pc", pc, 8'h10);
      cycle(1, 0, 0, 8'h00, 0, 8'h00, 1, 0);
      #1 check_eq("halted_set", halted, 1'b1);
      cycle(1, 0, 1, 8'h33, 0, 8'h00, 0, 0);
      idle(1);
      cycle(1, 0, 0, 8'h00, 0, 8'h00, 0, 1);
      #1 check_eq("resume_pc", pc, 8'h10);
      check_eq("resume_halted", halted, 1'b0);
      idle(1);

      // Reset mid-FLUSH
      cycle(1, 0, 1, 8'h20, 0, 8'h00, 0, 0);
      cycle(0, 0, 0, 8'h00, 0, 8'h00, 0, 0);
      #1 check_eq("rst_flush_pc", pc, 8'h00);
      check_eq("rst_flush_squash", squash, 1'b0);
      idle(1);

      // Randomized traffic
      for (int i = 0; i < 800; i++) begin
         cycle(($urandom_range(0, 59) != 0),
               ($urandom_range(0, 4) == 0),
               ($urandom_range(0, 7) == 0), 8'($urandom),
               ($urandom_range(0, 9) == 0), 8'($urandom),
               ($urandom_range(0, 14) == 0),
               ($urandom_range(0, 3) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
